// File: rtl/serial_add16_ctrl_pkg.sv
// Shared constants for the nibble-serial add/sub controller: digit width and FSM encoding.
package serial_add16_ctrl_pkg;

  localparam int NIB_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/serial_add16_ctrl_adder4.sv
// 4-bit carry-lookahead adder; all carries derived directly from generate/propagate terms.
module adder4 (
  output logic [3:0] s,
  output logic       cout,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       cin
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = A & B;
  assign p = A ^ B;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s = p ^ c;

endmodule

// File: rtl/serial_add16_ctrl.sv
// Nibble-serial add/subtract: one shared 4-bit CLA processes one digit per clock, LSB first.
module serial_add16_ctrl
  import serial_add16_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_valid,
  output logic                       start_ready,
  input  logic [NIB_W*NIBBLES-1:0]   op_a,
  input  logic [NIB_W*NIBBLES-1:0]   op_b,
  input  logic                       sub,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [NIB_W*NIBBLES-1:0]   result,
  output logic                       carry_out,
  output logic                       overflow,
  output logic                       zero
);

  localparam int W     = NIB_W * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  logic [1:0]       state;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx;

  logic [NIB_W-1:0] a_nib;
  logic [NIB_W-1:0] b_nib;
  logic [NIB_W-1:0] sum_nib;
  logic             cout_nib;
  logic [W-1:0]     res_next;

  assign start_ready = (state == ST_IDLE);
  assign res_valid   = (state == ST_DONE);

  assign a_nib = a_q[idx*NIB_W +: NIB_W];
  assign b_nib = b_q[idx*NIB_W +: NIB_W];

  adder4 u_adder4 (
    .s    (sum_nib),
    .cout (cout_nib),
    .A    (a_nib),
    .B    (b_nib),
    .cin  (carry_q)
  );

  // Full-width view of the result including the digit being written this cycle,
  // so the flags on the final edge see every bit.
  always_comb begin
    res_next = result;
    res_next[idx*NIB_W +: NIB_W] = sum_nib;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      idx       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_valid && start_ready) begin
            a_q     <= op_a;
            b_q     <= op_b ^ {W{sub}};
            carry_q <= sub;
            idx     <= '0;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          result  <= res_next;
          carry_q <= cout_nib;
          if (idx == IDX_LAST) begin
            state     <= ST_DONE;
            carry_out <= cout_nib;
            overflow  <= (a_q[W-1] == b_q[W-1]) && (res_next[W-1] != a_q[W-1]);
            zero      <= ~|res_next;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (res_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add16_ctrl.sv
// Table-driven and scoreboarded bench for the nibble-serial add/sub controller.
module tb_serial_add16_ctrl;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] res;
    logic        co;
    logic        ov;
    logic        z;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic        sub = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] result;
  logic        carry_out;
  logic        overflow;
  logic        zero;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t sb[$];
  vec_t vecs[10];

  serial_add16_ctrl #(.NIBBLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .sub         (sub),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .carry_out   (carry_out),
    .overflow    (overflow),
    .zero        (zero)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input vec_t e);
    check({tag, "_result"}, 32'(result), 32'(e.res));
    check({tag, "_carry"},  32'(carry_out), 32'(e.co));
    check({tag, "_ovf"},    32'(overflow), 32'(e.ov));
    check({tag, "_zero"},   32'(zero), 32'(e.z));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start_ready"}, 32'(start_ready), 32'd1);
    check({tag, "_res_valid"},   32'(res_valid), 32'd0);
    check({tag, "_result"},      32'(result), 32'd0);
    check({tag, "_carry"},       32'(carry_out), 32'd0);
    check({tag, "_ovf"},         32'(overflow), 32'd0);
    check({tag, "_zero"},        32'(zero), 32'd0);
  endtask

  // Called at a falling edge with the block idle.
  task automatic do_op(input vec_t v, input int hold, input string tag);
    int   cnt;
    vec_t e;
    check({tag, "_ready_idle"}, 32'(start_ready), 32'd1);
    op_a = v.a; op_b = v.b; sub = v.sub; start_valid = 1'b1;
    sb.push_back(v);
    @(negedge clk);
    start_valid = 1'b0;
    cnt = 0;
    while (!res_valid && cnt < 20) begin
      op_a = 16'($urandom); op_b = 16'($urandom); sub = 1'($urandom);
      @(negedge clk);
      cnt++;
    end
    check({tag, "_latency"}, 32'(cnt), 32'd4);
    if (sb.size() > 0) e = sb.pop_front(); else e = v;
    check_outputs(tag, e);
    check({tag, "_no_bypass"}, 32'(start_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      op_a = 16'($urandom); op_b = 16'($urandom);
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(res_valid), 32'd1);
      check_outputs({tag, "_hold"}, e);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_released"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    int   acc[$];
    int   cyc;
    int   cnt;
    vec_t e;
    vec_t v;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};

    // Reset state
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i], (i == 0) ? 3 : 0, $sformatf("vec%0d", i));
    end

    // Back-to-back with start_valid and res_ready held high
    op_a = 16'h0102; op_b = 16'h0304; sub = 1'b0;
    start_valid = 1'b1; res_ready = 1'b1;
    v = '{16'h0102, 16'h0304, 1'b0, 16'h0406, 1'b0, 1'b0, 1'b0};
    cyc = 0;
    for (int c = 0; c < 30; c++) begin
      if (start_valid && start_ready) begin
        acc.push_back(cyc);
        sb.push_back(v);
      end
      if (res_valid) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check_outputs("b2b", e);
        end else begin
          check("b2b_unexpected_result", 32'd1, 32'd0);
        end
      end
      @(negedge clk);
      cyc++;
    end
    start_valid = 1'b0;
    cnt = 0;
    while (sb.size() > 0 && cnt < 20) begin
      if (res_valid) begin
        e = sb.pop_front();
        check_outputs("b2b_drain", e);
      end
      @(negedge clk);
      cnt++;
    end
    res_ready = 1'b0;
    check("b2b_drained", 32'(sb.size()), 32'd0);
    check("b2b_accepts_ge3", 32'(acc.size() >= 3), 32'd1);
    if (acc.size() >= 3) begin
      check("b2b_spacing0", 32'(acc[1] - acc[0]), 32'd6);
      check("b2b_spacing1", 32'(acc[2] - acc[1]), 32'd6);
    end
    sb.delete();
    while (!start_ready && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end

    // Reset during the second RUN cycle aborts the operation
    op_a = 16'h1111; op_b = 16'h2222; sub = 1'b0; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (res_valid) cnt++;
    end
    check("midrun_no_result", 32'(cnt), 32'd0);
    do_op('{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0}, 0, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add16_ctrl.md
SERIAL_ADD16_CTRL -- requirements
Module: serial_add16_ctrl

Interface
REQ-001 Parameter NIBBLES, default 4: operand width in 4-bit digits; W = 4*NIBBLES; legal range 2..8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start_valid  input  1  requester presents an operation.
REQ-005 start_ready  output  1  block accepts an operation this cycle.
REQ-006 op_a  input  W  first operand, two's-complement or unsigned.
REQ-007 op_b  input  W  second operand.
REQ-008 sub  input  1  0 = A+B, 1 = A-B.
REQ-009 res_valid  output  1  result fields valid.
REQ-010 res_ready  input  1  consumer takes the result.
REQ-011 result  output  W  sum/difference.
REQ-012 carry_out  output  1  carry out of bit W-1 (for sub: 1 = no borrow).
REQ-013 overflow  output  1  signed overflow.
REQ-014 zero  output  1  result == 0.

Function
REQ-015 The block SHALL compute a W-bit add/sub nibble-serially with one shared 4-bit carry-lookahead adder, one nibble per clock, LSB nibble first.
REQ-016 FSM states SHALL be IDLE, RUN, DONE; start_ready = 1 only in IDLE; res_valid = 1 only in DONE.
REQ-017 IDLE: on start_valid && start_ready, capture op_a, op_b XOR {W{sub}}, and sub; set carry register = sub; clear nibble index; go to RUN.
REQ-018 RUN: each cycle, add nibble[idx] of A and B' with the carry register; write the sum to result nibble idx; store adder cout in the carry register; increment idx.
REQ-019 RUN: on the cycle where idx == NIBBLES-1, go to DONE after that edge; carry_out = final cout.
REQ-020 Latency: operation accepted at edge k gives res_valid = 1 after edge k+NIBBLES, i.e. exactly NIBBLES RUN cycles.
REQ-021 overflow SHALL be (A[W-1] == B'[W-1]) && (result[W-1] != A[W-1]), registered on the last RUN edge.
REQ-022 zero SHALL be 1 iff all W result bits are 0, registered on the last RUN edge.
REQ-023 DONE: result, carry_out, overflow, zero SHALL hold stable while res_ready = 0.
REQ-024 DONE: on res_ready = 1, go to IDLE; start_ready is not asserted in the same cycle (no bypass); minimum throughput is one operation per NIBBLES+2 cycles.
REQ-025 Operand inputs and start_valid SHALL be ignored outside IDLE; input changes during RUN SHALL not affect the result.
REQ-026 Nibble index SHALL not wrap in RUN; reaching NIBBLES-1 always terminates the operation.
REQ-027 The result of an operation SHALL be bit-exact to (A + (sub ? ~B+1 : B)) mod 2^W.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, start_ready = 1 once the FSM is in IDLE, res_valid = 0, result = 0, carry_out = 0, overflow = 0, zero = 0, carry register = 0, index = 0.
REQ-029 Reset asserted mid-RUN or in DONE SHALL abort the operation with no result delivered; first accept is allowed on the first edge after rst_n rises.

Structure
REQ-030 A shared package SHALL hold the FSM state enumeration (IDLE, RUN, DONE) and the nibble width constant 4.
REQ-031 Exactly one sub-module SHALL be instantiated: adder4 (4-bit carry-lookahead adder; ports s, cout, A, B, cin), with no second adder in the block.
REQ-032 The index counter width SHALL be clog2(NIBBLES).

Verification
REQ-033 NIBBLES=4, sub=0, 0x1234 + 0x4321 -> result 0x5555, carry_out 0, overflow 0, zero 0, res_valid 4 cycles after accept.
REQ-034 0xFFFF + 0x0001 -> result 0x0000, carry_out 1, zero 1, overflow 0; this checks carry propagation through all nibbles.
REQ-035 0x7FFF + 0x0001 -> result 0x8000, overflow 1, carry_out 0; 0x0005 - 0x0007 (sub=1) -> 0xFFFE, carry_out 0, overflow 0.
REQ-036 Hold res_ready low 3 cycles in DONE; outputs stay stable. Toggle op_a/op_b during RUN; the result is unchanged. start_valid held high gives back-to-back operations spaced NIBBLES+2 cycles apart.
REQ-037 Assert rst_n low during the second RUN cycle; all outputs go to reset values immediately, no res_valid follows, and the next operation 0x0001+0x0001 -> 0x0002.
